// File: rtl/vga_pkg.sv
// Shared VGA types: standard timing sets, DAC colour triple and test-bar colour map.
package vga_pkg;

    typedef struct packed {
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [11:0] h_act;
        logic [11:0] h_fp;
        logic [11:0] v_sync;
        logic [11:0] v_bp;
        logic [11:0] v_act;
        logic [11:0] v_fp;
        logic        h_pol;
        logic        v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_sync: 12'd96,  h_bp: 12'd48, h_act: 12'd640, h_fp: 12'd16,
        v_sync: 12'd2,   v_bp: 12'd33, v_act: 12'd480, v_fp: 12'd10,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_timing_t VGA_800x600_72 = '{
        h_sync: 12'd120, h_bp: 12'd64, h_act: 12'd800, h_fp: 12'd56,
        v_sync: 12'd6,   v_bp: 12'd23, v_act: 12'd600, v_fp: 12'd37,
        h_pol: 1'b1, v_pol: 1'b1
    };

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bar 0 is white, bar 7 is black; each channel follows one bit of (7-k).
    function automatic rgb_t bar_colour(input logic [2:0] k);
        logic [2:0] c;
        rgb_t       o;
        c   = 3'd7 - k;
        o.r = {8{c[2]}};
        o.g = {8{c[1]}};
        o.b = {8{c[0]}};
        return o;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with async active-low reset; DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst_n};
            assign o_q = i_d;
        end else begin : g_sr
            logic [DEPTH-1:0][WIDTH-1:0] r_sr;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with pixel-source latency compensation.
// Define VGA_TIMING_TESTPAT_EN to add test_en and an internal 8-bar colour generator.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC  = 128,
    parameter int H_BP    = 88,
    parameter int H_ACT   = 800,
    parameter int H_FP    = 40,
    parameter int V_SYNC  = 4,
    parameter int V_BP    = 23,
    parameter int V_ACT   = 600,
    parameter int V_FP    = 1,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int PIX_LAT = 1,
    parameter int XW      = 10,
    parameter int YW      = 10
) (
    input  logic          vga_clk,
    input  logic          resetn,
`ifdef VGA_TIMING_TESTPAT_EN
    input  logic          test_en,
`endif
    input  logic [7:0]    vga_r,
    input  logic [7:0]    vga_g,
    input  logic [7:0]    vga_b,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          req,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          VGA_CLK
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_S_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_A_BEG = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_A_END = HW'(H_SYNC + H_BP + H_ACT);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_S_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_A_BEG = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_A_END = VW'(V_SYNC + V_BP + V_ACT);

    generate
        if (H_SYNC == 0 || H_BP == 0 || H_ACT == 0 || H_FP == 0 ||
            V_SYNC == 0 || V_BP == 0 || V_ACT == 0 || V_FP == 0) begin : g_err_zero
            $error("vga_timing_gen: timing parameters must be non-zero");
        end
        if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_err_lat
            $error("vga_timing_gen: PIX_LAT must be 0..7");
        end
        if (H_ACT > (1 << XW) || V_ACT > (1 << YW)) begin : g_err_width
            $error("vga_timing_gen: XW/YW too narrow for active area");
        end
    endgenerate

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Stage 0: decode straight from the counters.
    logic          w_hs, w_vs, w_act;
    logic [HW-1:0] w_hoff;
    logic [VW-1:0] w_voff;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    assign w_hs   = r_hcnt < H_S_END;
    assign w_vs   = r_vcnt < V_S_END;
    assign w_act  = (r_hcnt >= H_A_BEG) && (r_hcnt < H_A_END) &&
                    (r_vcnt >= V_A_BEG) && (r_vcnt < V_A_END);
    assign w_hoff = r_hcnt - H_A_BEG;
    assign w_voff = r_vcnt - V_A_BEG;
    assign w_x    = w_act ? XW'(w_hoff) : '0;
    assign w_y    = w_act ? YW'(w_voff) : '0;

    logic r_hs, r_vs;

    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            req         <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_hs        <= w_hs;
            r_vs        <= w_vs;
            req         <= w_act;
            x           <= w_x;
            y           <= w_y;
            line_start  <= w_act && (w_x == '0);
            frame_start <= w_act && (w_x == '0) && (w_y == '0);
        end
    end

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
    localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    logic [2:0]    r_bar_k;
    logic [CW-1:0] r_bar_cnt;
    logic [2:0]    w_k;
    logic [CW-1:0] w_cnt;
    logic          r_tp;
    rgb_t          r_bar_rgb;

    // Bar state for the pixel being requested now; x=0 restarts the line at bar 0.
    assign w_k   = (w_x == '0) ? 3'd0 : r_bar_k;
    assign w_cnt = (w_x == '0) ? '0   : r_bar_cnt;

    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            r_bar_k   <= '0;
            r_bar_cnt <= '0;
            r_tp      <= 1'b0;
            r_bar_rgb <= '0;
        end else begin
            if (w_act) begin
                if (w_cnt == BAR_LAST) begin
                    r_bar_k   <= w_k + 3'd1;
                    r_bar_cnt <= '0;
                end else begin
                    r_bar_k   <= w_k;
                    r_bar_cnt <= w_cnt + 1'b1;
                end
            end
            r_tp      <= test_en;
            r_bar_rgb <= bar_colour(w_k);
        end
    end

    localparam int PW = 3 + 1 + 24;
    logic [PW-1:0] w_pipe_in, w_pipe_out;
    logic          w_hs_d, w_vs_d, w_act_d, w_tp_d;
    rgb_t          w_bar_d;
    rgb_t          w_src;

    assign w_pipe_in = {r_hs, r_vs, req, r_tp, r_bar_rgb};
    assign {w_hs_d, w_vs_d, w_act_d, w_tp_d, w_bar_d} = w_pipe_out;
    assign w_src = w_tp_d ? w_bar_d : rgb_t'({vga_r, vga_g, vga_b});
`else
    localparam int PW = 3;
    logic [PW-1:0] w_pipe_in, w_pipe_out;
    logic          w_hs_d, w_vs_d, w_act_d;
    rgb_t          w_src;

    assign w_pipe_in = {r_hs, r_vs, req};
    assign {w_hs_d, w_vs_d, w_act_d} = w_pipe_out;
    assign w_src = rgb_t'({vga_r, vga_g, vga_b});
`endif

    // Delays sync/blank by the pixel-source latency so they meet RGB at the DAC.
    vga_delay_line #(
        .WIDTH (PW),
        .DEPTH (PIX_LAT)
    ) u_align (
        .i_clk   (vga_clk),
        .i_rst_n (resetn),
        .i_d     (w_pipe_in),
        .o_q     (w_pipe_out)
    );

    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            VGA_HS      <= ~H_POL;
            VGA_VS      <= ~V_POL;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else begin
            VGA_HS      <= w_hs_d ? H_POL : ~H_POL;
            VGA_VS      <= w_vs_d ? V_POL : ~V_POL;
            VGA_BLANK_N <= w_act_d;
            VGA_R       <= w_act_d ? w_src.r : 8'h00;
            VGA_G       <= w_act_d ? w_src.g : 8'h00;
            VGA_B       <= w_act_d ? w_src.b : 8'h00;
        end
    end

    assign VGA_SYNC_N = 1'b0;
    assign VGA_CLK    = vga_clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-source bench for vga_timing_gen on a shrunken timing set, checked
// against an arithmetic model of the raster position.
module tb_vga_timing_gen;

    localparam int H_SYNC = 4, H_BP = 3, H_ACT = 16, H_FP = 2;
    localparam int V_SYNC = 2, V_BP = 2, V_ACT = 6,  V_FP = 1;
    localparam bit H_POL  = 1'b0;
    localparam bit V_POL  = 1'b1;
    localparam int L      = 3;
    localparam int XW     = 4;
    localparam int YW     = 3;
    localparam int H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int F_TOT  = H_TOT * V_TOT;
    localparam int HA0    = H_SYNC + H_BP;
    localparam int VA0    = V_SYNC + V_BP;

    logic          vga_clk = 1'b0;
    logic          resetn;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          req, line_start, frame_start;
    logic [7:0]    VGA_R, VGA_G, VGA_B;
    logic          VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
`ifdef VGA_TIMING_TESTPAT_EN
    logic          test_en;
`endif

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
        .H_POL(H_POL), .V_POL(V_POL), .PIX_LAT(L), .XW(XW), .YW(YW)
    ) dut (
        .vga_clk(vga_clk), .resetn(resetn),
`ifdef VGA_TIMING_TESTPAT_EN
        .test_en(test_en),
`endif
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .x(x), .y(y), .req(req), .line_start(line_start), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
    );

    always #5 vga_clk = ~vga_clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n      = 0;     // rising edges since reset release
    bit          tp_on  = 1'b0;
    int unsigned ka, kb, seed;
    logic [23:0] srcq[$];

    function automatic logic [23:0] pix(int xx, int yy);
        return {8'(xx + int'(seed)), 8'(yy * 7 + int'(ka)), 8'(xx ^ (yy << 4) ^ int'(kb))};
    endfunction

    function automatic logic [23:0] bar(int xx);
        int c;
        c = 7 - xx / (H_ACT / 8);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    function automatic bit in_act(int hh, int vv);
        return hh >= HA0 && hh < HA0 + H_ACT && vv >= VA0 && vv < VA0 + V_ACT;
    endfunction

    // {req, line_start, frame_start, x, y} expected after nn edges.
    function automatic logic [3+XW+YW-1:0] exp_s1(int nn);
        int p, hh, vv, xx, yy;
        bit a;
        if (nn < 1) return '0;
        p  = nn - 1;
        hh = p % H_TOT;
        vv = (p / H_TOT) % V_TOT;
        a  = in_act(hh, vv);
        xx = a ? hh - HA0 : 0;
        yy = a ? vv - VA0 : 0;
        return {a, a && xx == 0, a && xx == 0 && yy == 0, XW'(xx), YW'(yy)};
    endfunction

    // {HS, VS, BLANK_N, R, G, B} expected after nn edges.
    function automatic logic [26:0] exp_out(int nn);
        int q, hh, vv;
        bit a;
        logic [23:0] col;
        q = nn - 2 - L;
        if (q < 0) return {~H_POL, ~V_POL, 1'b0, 24'h0};
        hh  = q % H_TOT;
        vv  = (q / H_TOT) % V_TOT;
        a   = in_act(hh, vv);
        col = !a ? 24'h0 : (tp_on ? bar(hh - HA0) : pix(hh - HA0, vv - VA0));
        return {(hh < H_SYNC) ? H_POL : ~H_POL, (vv < V_SYNC) ? V_POL : ~V_POL, a, col};
    endfunction

    // Advance one clock; the pixel source answers each request L cycles later.
    task automatic step();
        @(posedge vga_clk);
        n++;
        @(negedge vga_clk);
        srcq.push_back(req ? pix(int'(x), int'(y)) : 24'($urandom));
        if (srcq.size() > L + 1) srcq.delete(0);
        {vga_r, vga_g, vga_b} = (srcq.size() == L + 1) ? srcq[0] : 24'($urandom);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        {vga_r, vga_g, vga_b} = 24'hFFFFFF;
        #2 resetn = 1'b0;
        #1;
        n_chk++;
        if ({req, line_start, frame_start, x, y} !== '0)
            $display("FAIL reset_s1 got %b want 0", {req, line_start, frame_start, x, y});
        else n_pass++;
        n_chk++;
        if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {~H_POL, ~V_POL, 1'b0, 24'h0})
            $display("FAIL reset_out got %h want %h", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B},
                     {~H_POL, ~V_POL, 1'b0, 24'h0});
        else n_pass++;
        repeat (3) step();
        n_chk++;
        if ({req, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R} !== {1'b0, ~H_POL, ~V_POL, 1'b0, 8'h0})
            $display("FAIL reset_held got %h", {req, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R});
        else n_pass++;
        n_chk++;
        if (VGA_SYNC_N !== 1'b0 || VGA_CLK !== vga_clk)
            $display("FAIL sync_clk got sync_n=%b clk=%b want 0 and %b", VGA_SYNC_N, VGA_CLK, vga_clk);
        else n_pass++;
        resetn = 1'b1;
        n = 0;
    endtask

    task automatic test_timing(int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            n_chk++;
            if ({req, line_start, frame_start, x, y} !== exp_s1(n))
                $display("FAIL timing_s1 n=%0d got %b want %b", n, {req, line_start, frame_start, x, y}, exp_s1(n));
            else n_pass++;
            n_chk++;
            if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== exp_out(n))
                $display("FAIL timing_out n=%0d got %h want %h", n,
                         {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, exp_out(n));
            else n_pass++;
        end
    endtask

    task automatic test_frame_stats();
        int blanks = 0, hs_act = 0, vs_act = 0, ls = 0, ls_bad = 0, fs = 0, rgb_bad = 0;
        int fs_a = -1, fs_b = -1;
        for (int i = 0; i < 3 * F_TOT; i++) begin
            step();
            if (frame_start) begin
                if (fs_a < 0) fs_a = n;
                else if (fs_b < 0) fs_b = n;
            end
            if (!VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'h0) rgb_bad++;
            if (i < F_TOT) begin
                blanks += int'(VGA_BLANK_N);
                hs_act += int'(VGA_HS == H_POL);
                vs_act += int'(VGA_VS == V_POL);
                ls     += int'(line_start);
                fs     += int'(frame_start);
                if (line_start && x != '0) ls_bad++;
            end
        end
        n_chk++;
        if (blanks !== H_ACT * V_ACT) $display("FAIL blank_count got %0d want %0d", blanks, H_ACT * V_ACT);
        else n_pass++;
        n_chk++;
        if (hs_act !== H_SYNC * V_TOT) $display("FAIL hs_count got %0d want %0d", hs_act, H_SYNC * V_TOT);
        else n_pass++;
        n_chk++;
        if (vs_act !== V_SYNC * H_TOT) $display("FAIL vs_count got %0d want %0d", vs_act, V_SYNC * H_TOT);
        else n_pass++;
        n_chk++;
        if (ls !== V_ACT || ls_bad !== 0) $display("FAIL line_start got %0d (bad x %0d) want %0d", ls, ls_bad, V_ACT);
        else n_pass++;
        n_chk++;
        if (fs !== 1) $display("FAIL frame_start_count got %0d want 1", fs);
        else n_pass++;
        n_chk++;
        if (fs_b - fs_a !== F_TOT || fs_a < 0) $display("FAIL frame_period got %0d want %0d", fs_b - fs_a, F_TOT);
        else n_pass++;
        n_chk++;
        if (rgb_bad !== 0) $display("FAIL rgb_in_blank got %0d want 0", rgb_bad);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int tgt, got = -1;
        tgt = (VA0 + int'($urandom_range(V_ACT - 1))) * H_TOT + HA0 + 1 + int'($urandom_range(H_ACT - 2));
        for (int i = 0; i < 2 * F_TOT && (n % F_TOT) != tgt; i++) step();
        n_chk++;
        if ((n % F_TOT) != tgt) $display("FAIL midrst_reach got %0d want %0d", n % F_TOT, tgt);
        else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_chk++;
        if ({req, line_start, frame_start, x, y} !== '0)
            $display("FAIL midrst_s1 got %b want 0", {req, line_start, frame_start, x, y});
        else n_pass++;
        n_chk++;
        if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {~H_POL, ~V_POL, 1'b0, 24'h0})
            $display("FAIL midrst_out got %h", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B});
        else n_pass++;
        repeat (2) step();
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * F_TOT && got < 0; i++) begin
            step();
            if (frame_start) got = n;
        end
        n_chk++;
        if (got !== VA0 * H_TOT + HA0 + 1 || x !== '0 || y !== '0)
            $display("FAIL midrst_first_frame got edge %0d x=%0d y=%0d want edge %0d", got, x, y, VA0 * H_TOT + HA0 + 1);
        else n_pass++;
    endtask

`ifdef VGA_TIMING_TESTPAT_EN
    task automatic test_testpat();
        test_en = 1'b1;
        tp_on   = 1'b1;
        repeat (F_TOT) step();
        for (int i = 0; i < F_TOT; i++) begin
            step();
            n_chk++;
            if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== exp_out(n)[24:0])
                $display("FAIL testpat n=%0d got %h want %h", n, {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, exp_out(n)[24:0]);
            else n_pass++;
        end
        test_en = 1'b0;
        tp_on   = 1'b0;
        repeat (F_TOT) step();
    endtask
`endif

    initial begin
        ka   = $urandom;
        kb   = $urandom;
        seed = $urandom;
`ifdef VGA_TIMING_TESTPAT_EN
        test_en = 1'b0;
`endif
        test_reset();
        test_timing(2 * F_TOT + 10);
        test_frame_stats();
        test_mid_reset();
        test_timing(F_TOT + 20);
`ifdef VGA_TIMING_TESTPAT_EN
        test_testpat();
        test_timing(F_TOT);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
